// File: rtl/mpt_walk_arbiter_pkg.sv
// mpt_walk_arbiter_pkg: shared types for the MPT walk arbiter and its walker interface
package mpt_walk_arbiter_pkg;

    localparam int PLEN = 34;

    typedef enum logic [3:0] {
        MPT_BARE = 4'd0,
        MPT_34   = 4'd1,
        MPT_43   = 4'd2,
        MPT_52   = 4'd3,
        MPT_46   = 4'd4
    } mpt_mode_e;

    typedef enum logic [1:0] {
        ACCESS_READ  = 2'd0,
        ACCESS_WRITE = 2'd1,
        ACCESS_EXEC  = 2'd2
    } mpt_access_e;

    typedef enum logic [2:0] {
        NO_ERROR           = 3'd0,
        NOT_VALID_ADDR     = 3'd1,
        RESERVED_BITS      = 3'd2,
        INVALID_MPTL1_INFO = 3'd3,
        INVALID_MPTL2_INFO = 3'd4,
        INVALID_MPTL3_INFO = 3'd5
    } page_format_fault_e;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} mpt_arb_state_e;

    typedef struct packed {
        logic [PLEN-1:0] PADDR;
        mpt_access_e     ACCESS;
    } mpt_walk_req_t;

    // Modes that need a table walk; BARE bypasses and anything unlisted is reserved.
    function automatic logic mode_walks(input mpt_mode_e m);
        return m inside {MPT_34, MPT_43, MPT_52, MPT_46};
    endfunction

endpackage

// File: rtl/mpt_walk_arbiter_if.sv
// mpt_walk_arbiter_if: request/response handshake between the arbiter and the MPT walker
interface mpt_walk_arbiter_if;
    import mpt_walk_arbiter_pkg::*;

    logic               valid;
    logic               ready;
    logic [PLEN-1:0]    paddr;
    mpt_access_e        access;
    logic               flush;
    logic               done;
    logic               allow;
    page_format_fault_e fault;

    modport master (output valid, paddr, access, flush, input ready, done, allow, fault);
    modport slave  (input valid, paddr, access, flush, output ready, done, allow, fault);

endinterface

// File: rtl/mpt_walk_arbiter_rr.sv
// mpt_rr_arbiter: round-robin masked priority encoder starting the search at rr_ptr
module mpt_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] ptr, input int i);
        int v = int'(ptr) + i;
        return ID_W'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    // Scan in reverse search order so the last hit is the first requester after rr_ptr.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[slot(rr_ptr, i)]) begin
                gnt                   = '0;
                gnt[slot(rr_ptr, i)]  = 1'b1;
                gnt_id                = slot(rr_ptr, i);
            end
        end
    end

endmodule

// File: rtl/mpt_walk_arbiter.sv
// mpt_walk_arbiter: shares one MPT walker between NUM_REQ requesters, one walk at a time
module mpt_walk_arbiter
    import mpt_walk_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  mpt_mode_e               mode_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*PLEN-1:0] req_paddr_i,
    input  logic [NUM_REQ*2-1:0]    req_access_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    mpt_walk_arbiter_if.master      walk,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic                    rsp_allow_o,
    output page_format_fault_e      rsp_fault_o
);

    mpt_arb_state_e     state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, id_q, gnt_id;
    logic [NUM_REQ-1:0] gnt;
    mpt_walk_req_t      req_q;
    logic               allow_q, flush_q, grant, capture;
    page_format_fault_e fault_q;

    mpt_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req    (req_valid_i),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // rst_ni gates the accept pulse so nothing is acknowledged while held in reset.
    assign grant   = rst_ni && state_q == ARB_IDLE && !flush_i && |req_valid_i;
    assign capture = state_q == ARB_WAIT && walk.done && !flush_i;

    assign req_ready_o = grant ? gnt : '0;
    assign rsp_valid_o = (state_q == ARB_RESP && !flush_i) ? NUM_REQ'(1) << id_q : '0;
    assign rsp_allow_o = allow_q;
    assign rsp_fault_o = fault_q;
    assign walk.valid  = state_q == ARB_ISSUE && !flush_i;
    assign walk.paddr  = req_q.PADDR;
    assign walk.access = req_q.ACCESS;
    assign walk.flush  = flush_q;

    // Next state; flush overrides everything and returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  state_d = grant ? (mode_walks(mode_i) ? ARB_ISSUE : ARB_RESP) : ARB_IDLE;
            ARB_ISSUE: state_d = walk.ready ? ARB_WAIT : ARB_ISSUE;
            ARB_WAIT:  state_d = walk.done ? ARB_RESP : ARB_WAIT;
            default:   state_d = ARB_IDLE;
        endcase
        if (flush_i) state_d = ARB_IDLE;
    end

    // State, round-robin pointer, latched request and captured response fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            req_q    <= '0;
            allow_q  <= 1'b0;
            fault_q  <= NO_ERROR;
            flush_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_i;
            if (grant) begin
                rr_ptr_q <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
                id_q     <= gnt_id;
                req_q    <= '{PADDR: req_paddr_i[gnt_id*PLEN +: PLEN],
                              ACCESS: mpt_access_e'(req_access_i[gnt_id*2 +: 2])};
            end
            if (grant && !mode_walks(mode_i)) begin
                allow_q <= mode_i == MPT_BARE;
                fault_q <= mode_i == MPT_BARE ? NO_ERROR : NOT_VALID_ADDR;
            end else if (capture) begin
                allow_q <= walk.allow;
                fault_q <= walk.fault;
            end
        end
    end

endmodule
